// File: rtl/sseg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package sseg_pkg;

    localparam logic [7:0] SSEG_OFF_N = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    typedef enum logic {S_BLANK, S_ON} scan_state_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module hex_to_sseg (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7F;
        case (hex)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
            default: seg_n = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with blanking gap and
// frame-synchronous double-buffered display data.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*N_DIGITS-1:0] i_hex,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_digit_en,
    input  logic                  i_load,
    output logic                  o_load_ack,
    output logic                  o_frame,
    output logic [N_DIGITS-1:0]   o_an_n,
    output logic [7:0]            o_sseg_n
);

    localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("sseg_scan_ctrl: N_DIGITS must be 1..%0d", MAX_DIGITS);
    end
    if (DIGIT_TICKS < 2) begin : g_bad_slot
        $error("sseg_scan_ctrl: DIGIT_TICKS must be >= 2");
    end
    if (BLANK_TICKS < 1 || BLANK_TICKS >= DIGIT_TICKS) begin : g_bad_blank
        $error("sseg_scan_ctrl: BLANK_TICKS must be 1..DIGIT_TICKS-1");
    end

    logic [TW-1:0] tick;
    logic [IW-1:0] idx;
    scan_state_t   state;
    logic          slot_end;
    logic          frame_end;

    assign slot_end  = (tick == TICK_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick  <= '0;
            idx   <= '0;
            state <= S_BLANK;
        end else begin
            tick <= slot_end ? '0 : tick + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            case (state)
                S_BLANK: if (tick == BLANK_LAST) state <= S_ON;
                S_ON:    if (slot_end)           state <= S_BLANK;
                default:                         state <= S_BLANK;
            endcase
        end
    end

    logic [N_DIGITS-1:0][3:0] stg_hex, disp_hex;
    logic [N_DIGITS-1:0]      stg_dp, disp_dp;
    logic [N_DIGITS-1:0]      stg_en, disp_en;
    logic                     pending;
    logic                     commit;

    // A load presented in the boundary cycle bypasses staging so it is not
    // deferred a whole frame.
    assign commit = frame_end && (pending || i_load);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stg_hex  <= '0;
            stg_dp   <= '0;
            stg_en   <= '0;
            disp_hex <= '0;
            disp_dp  <= '0;
            disp_en  <= '0;
            pending  <= 1'b0;
        end else begin
            if (i_load) begin
                stg_hex <= i_hex;
                stg_dp  <= i_dp;
                stg_en  <= i_digit_en;
            end
            if (commit) begin
                disp_hex <= i_load ? i_hex      : stg_hex;
                disp_dp  <= i_load ? i_dp       : stg_dp;
                disp_en  <= i_load ? i_digit_en : stg_en;
                pending  <= 1'b0;
            end else if (i_load) begin
                pending  <= 1'b1;
            end
        end
    end

    logic [3:0] cur_hex;
    logic       cur_dp;
    logic       cur_en;
    logic [6:0] dec_seg_n;

    assign cur_hex = disp_hex[idx];
    assign cur_dp  = disp_dp[idx];
    assign cur_en  = disp_en[idx];

    hex_to_sseg u_dec (
        .hex   (cur_hex),
        .seg_n (dec_seg_n)
    );

    // Disabled digits still occupy their slot so brightness stays uniform.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_an_n     <= '1;
            o_sseg_n   <= SSEG_OFF_N;
            o_load_ack <= 1'b0;
            o_frame    <= 1'b0;
        end else begin
            o_frame    <= frame_end;
            o_load_ack <= commit;
            if (state == S_ON && cur_en) begin
                o_an_n   <= ~(N_DIGITS'(1) << idx);
                o_sseg_n <= {~cur_dp, dec_seg_n};
            end else begin
                o_an_n   <= '1;
                o_sseg_n <= SSEG_OFF_N;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with a per-frame expected-output scoreboard.
module tb_sseg_scan_ctrl;

    localparam int N  = 4;
    localparam int DT = 8;
    localparam int BT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*N-1:0] hex = '0;
    logic [N-1:0]  dp  = '0;
    logic [N-1:0]  en  = '0;
    logic          load = 1'b0;
    logic          o_load_ack, o_frame;
    logic [N-1:0]  o_an_n;
    logic [7:0]    o_sseg_n;

    sseg_scan_ctrl #(.N_DIGITS(N), .DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_hex      (hex),
        .i_dp       (dp),
        .i_digit_en (en),
        .i_load     (load),
        .o_load_ack (o_load_ack),
        .o_frame    (o_frame),
        .o_an_n     (o_an_n),
        .o_sseg_n   (o_sseg_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_assert   = 0;
    int n_fail     = 0;
    int ack_cnt    = 0;
    int cyc        = 0;
    int last_frame = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every sample point also runs the always-on checks.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (o_load_ack === 1'b1) ack_cnt++;
        chk("an_onehot0", 32'($onehot0(~o_an_n)), 32'd1);
        if (o_frame === 1'b1) begin
            if (last_frame >= 0) chk("frame_period", cyc - last_frame, 32);
            last_frame = cyc;
        end
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
        hex  = h;
        dp   = d;
        en   = e;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output int lat);
        int found;
        found = 0;
        lat   = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (o_load_ack === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk({tag, "_ack_seen"}, found, 1);
        chk({tag, "_ack_with_frame"}, o_frame, 1);
    endtask

    // Called on the cycle showing o_frame; the next 32 samples are one frame.
    task automatic check_frame(input string tag, input logic [15:0] h,
                               input logic [3:0] d, input logic [3:0] e);
        exp_t x;
        for (int k = 0; k < 32; k++) begin
            int s, t;
            s = k / DT;
            t = k % DT;
            if (t >= BT && e[s])
                sb.push_back('{an: ~(4'b0001 << s), seg: {~d[s], seg_tab[h[4*s +: 4]]}});
            else
                sb.push_back('{an: 4'hF, seg: 8'hFF});
        end
        for (int k = 0; k < 32; k++) begin
            tick();
            x = sb.pop_front();
            chk({tag, "_an"},  o_an_n,   x.an);
            chk({tag, "_seg"}, o_sseg_n, x.seg);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, low_seen, first_frame, base;

        // 1. reset, then dark display until something is loaded
        repeat (3) tick();
        chk("rst_an",    o_an_n,     4'hF);
        chk("rst_seg",   o_sseg_n,   8'hFF);
        chk("rst_ack",   o_load_ack, 0);
        chk("rst_frame", o_frame,    0);
        rst = 1'b0;
        last_frame  = -1;
        low_seen    = 0;
        first_frame = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_an_n !== 4'hF) low_seen++;
            if (o_frame === 1'b1 && first_frame < 0) first_frame = i + 1;
        end
        chk("s1_dark",        low_seen,    0);
        chk("s1_first_frame", first_frame, 32);

        // 2. basic load and scan
        do_load(16'h1234, 4'h0, 4'hF);
        wait_ack("s2", lat);
        chk("s2_latency_le_33", 32'(lat + 1 <= 33), 1);
        check_frame("s2", 16'h1234, 4'h0, 4'hF);

        // 3. disabled digit 2 and decimal point on digit 0
        do_load(16'h1234, 4'b0001, 4'b1011);
        wait_ack("s3", lat);
        check_frame("s3", 16'h1234, 4'b0001, 4'b1011);

        // 4. two loads in one frame: last wins, single ack
        base = ack_cnt;
        do_load(16'hAAAA, 4'h0, 4'hF);
        repeat (2) tick();
        do_load(16'h5555, 4'h0, 4'hF);
        wait_ack("s4", lat);
        check_frame("s4", 16'h5555, 4'h0, 4'hF);
        chk("s4_one_ack", ack_cnt - base, 1);

        // 5. load presented exactly in the frame-boundary cycle
        repeat (31) tick();
        hex  = 16'h9876;
        dp   = 4'h0;
        en   = 4'hF;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("s5_ack_next", o_load_ack, 1);
        chk("s5_frame",    o_frame,    1);
        check_frame("s5", 16'h9876, 4'h0, 4'hF);

        // 6. asynchronous reset while a digit is lit
        repeat (3) tick();
        chk("s6_lit_before", o_an_n, 4'b1110);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_an",  o_an_n,   4'hF);
        chk("s6_async_seg", o_sseg_n, 8'hFF);
        repeat (2) tick();
        rst = 1'b0;
        last_frame  = -1;
        low_seen    = 0;
        first_frame = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_an_n !== 4'hF) low_seen++;
            if (o_frame === 1'b1 && first_frame < 0) first_frame = i + 1;
        end
        chk("s6_cleared",       low_seen,    0);
        chk("s6_restart_frame", first_frame, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
